// File: rtl/lc89_pkg.sv
// rtl/lc89_pkg.sv - shared widths, beat-count helper and access direction for lc89
package lc89_pkg;

    localparam int LC89_DATA_W  = 4;
    localparam int LC89_REG_W   = 8;
    localparam int LC89_ADDR_W  = 4;
    localparam int LC89_AUTOINC = 1;

    typedef enum logic {
        DIR_WR = 1'b0,
        DIR_RD = 1'b1
    } lc89_dir_e;

    function automatic int lc89_nb(input int reg_w, input int data_w);
        return reg_w / data_w;
    endfunction

endpackage

// File: rtl/lc89_strobe_sync.sv
// rtl/lc89_strobe_sync.sv - 2-flop synchroniser and falling-edge detector for a host strobe
module lc89_strobe_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic strobe_n_i,
    output logic fall_o
);

    logic s1_q, s2_q, hist_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            hist_q <= 1'b1;
        end else begin
            s1_q   <= strobe_n_i;
            s2_q   <= s1_q;
            hist_q <= s2_q;
        end
    end

    assign fall_o = hist_q & ~s2_q;

endmodule

// File: rtl/lc89_regif.sv
// rtl/lc89_regif.sv - indirect host register interface with multi-beat coherent access
module lc89_regif
    import lc89_pkg::*;
#(
    parameter int DATA_W  = LC89_DATA_W,
    parameter int REG_W   = LC89_REG_W,
    parameter int ADDR_W  = LC89_ADDR_W,
    parameter int AUTOINC = LC89_AUTOINC
) (
    input  logic              CLK_12M,
    input  logic              RESET,
    input  logic              nWR,
    input  logic              nRD,
    input  logic              RS,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] DOUT,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [REG_W-1:0]  RD_DATA,
    output logic              WR_STB,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [REG_W-1:0]  WR_DATA,
    output logic              RDC_STB,
    output logic [ADDR_W-1:0] RDC_ADDR
);

    localparam int NB = lc89_nb(REG_W, DATA_W);
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    logic wr_fall, rd_fall;

    lc89_strobe_sync u_wr_sync (.clk_i(CLK_12M), .rst_i(RESET), .strobe_n_i(nWR), .fall_o(wr_fall));
    lc89_strobe_sync u_rd_sync (.clk_i(CLK_12M), .rst_i(RESET), .strobe_n_i(nRD), .fall_o(rd_fall));

    logic [ADDR_W-1:0] ar_q, ar_d, ar_inc;
    logic [BW-1:0]     beat_q, beat_d, beat_eff;
    lc89_dir_e         dir_q, dir_d, acc_dir;
    logic [REG_W-1:0]  hold_q, hold_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              wr_stb_q, wr_stb_d, rdc_stb_q, rdc_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rdc_addr_q, rdc_addr_d;
    logic [REG_W-1:0]  wr_data_q, wr_data_d;
    int                idx;

    // Index 0 never auto-increments, so a wrap to 0 parks the pointer there.
    assign ar_inc = (AUTOINC != 0 && ar_q != '0) ? ar_q + 1'b1 : ar_q;

    always_comb begin
        ar_d       = ar_q;
        beat_d     = beat_q;
        dir_d      = dir_q;
        hold_d     = hold_q;
        dout_d     = dout_q;
        wr_stb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rdc_stb_d  = 1'b0;
        rdc_addr_d = rdc_addr_q;
        acc_dir    = wr_fall ? DIR_WR : DIR_RD;
        beat_eff   = (dir_q == acc_dir) ? beat_q : '0;
        idx        = int'(beat_eff) * DATA_W;

        if (wr_fall) begin
            if (!RS) begin
                ar_d   = DIN[ADDR_W-1:0];
                beat_d = '0;
            end else begin
                dir_d = DIR_WR;
                hold_d[idx +: DATA_W] = DIN;
                if (beat_eff == LAST_BEAT) begin
                    wr_stb_d  = 1'b1;
                    wr_addr_d = ar_q;
                    wr_data_d = hold_d;
                    beat_d    = '0;
                    ar_d      = ar_inc;
                end else begin
                    beat_d = beat_eff + 1'b1;
                end
            end
        end else if (rd_fall) begin
            if (!RS) begin
                dout_d = DATA_W'(ar_q);
            end else begin
                dir_d = DIR_RD;
                // Beat 0 snapshots the whole register so later beats stay coherent.
                if (beat_eff == '0) begin
                    hold_d = RD_DATA;
                    dout_d = RD_DATA[DATA_W-1:0];
                end else begin
                    dout_d = hold_q[idx +: DATA_W];
                end
                if (beat_eff == LAST_BEAT) begin
                    rdc_stb_d  = 1'b1;
                    rdc_addr_d = ar_q;
                    beat_d     = '0;
                    ar_d       = ar_inc;
                end else begin
                    beat_d = beat_eff + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK_12M) begin
        if (RESET) begin
            ar_q       <= '0;
            beat_q     <= '0;
            dir_q      <= DIR_WR;
            hold_q     <= '0;
            dout_q     <= '0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rdc_stb_q  <= 1'b0;
            rdc_addr_q <= '0;
        end else begin
            ar_q       <= ar_d;
            beat_q     <= beat_d;
            dir_q      <= dir_d;
            hold_q     <= hold_d;
            dout_q     <= dout_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rdc_stb_q  <= rdc_stb_d;
            rdc_addr_q <= rdc_addr_d;
        end
    end

    assign DOUT     = dout_q;
    assign RD_ADDR  = ar_q;
    assign WR_STB   = wr_stb_q;
    assign WR_ADDR  = wr_addr_q;
    assign WR_DATA  = wr_data_q;
    assign RDC_STB  = rdc_stb_q;
    assign RDC_ADDR = rdc_addr_q;

endmodule

// File: tb/tb_lc89_regif.sv
// tb/tb_lc89_regif.sv - randomized scoreboard bench for lc89_regif
module tb_lc89_regif;

    localparam int DW = 4;
    localparam int RW = 8;
    localparam int AW = 4;
    localparam int NB = RW / DW;
    localparam int DEPTH = 1 << AW;
    localparam int AUTOINC = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic nwr = 1'b1, nrd = 1'b1, rs = 1'b0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic [AW-1:0] rd_addr;
    logic [RW-1:0] rd_data;
    logic wr_stb, rdc_stb;
    logic [AW-1:0] wr_addr, rdc_addr;
    logic [RW-1:0] wr_data;

    logic [RW-1:0] core_mem [DEPTH];
    assign rd_data = core_mem[rd_addr];

    always #5 clk = ~clk;

    lc89_regif #(.DATA_W(DW), .REG_W(RW), .ADDR_W(AW), .AUTOINC(AUTOINC)) dut (
        .CLK_12M(clk), .RESET(reset), .nWR(nwr), .nRD(nrd), .RS(rs), .DIN(din),
        .DOUT(dout), .RD_ADDR(rd_addr), .RD_DATA(rd_data),
        .WR_STB(wr_stb), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
        .RDC_STB(rdc_stb), .RDC_ADDR(rdc_addr)
    );

    typedef struct { logic [AW-1:0] addr; logic [RW-1:0] data; } wr_exp_t;
    typedef struct { logic [AW-1:0] ar; logic [DW-1:0] dout; bit rst; } chk_t;

    wr_exp_t       wr_q[$];
    logic [AW-1:0] rdc_q[$];
    chk_t          chk_q[$];
    bit            final_chk = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    // Reference model: pending write beats collected in a queue, reads served from a snapshot.
    int            m_ar, m_rbeat;
    int            m_dir;          // 0 = write, 1 = read
    logic [DW-1:0] m_dout;
    logic [RW-1:0] m_snap;
    logic [DW-1:0] m_wbeats[$];

    function automatic void m_reset();
        m_ar = 0; m_rbeat = 0; m_dir = 0; m_dout = '0; m_snap = '0;
        m_wbeats.delete();
    endfunction

    function automatic void m_inc();
        if (AUTOINC != 0 && m_ar != 0) m_ar = (m_ar + 1) % DEPTH;
    endfunction

    function automatic void m_write(input bit sel, input logic [DW-1:0] d);
        logic [RW-1:0] v;
        if (!sel) begin
            m_ar = int'(d) % DEPTH;
            m_wbeats.delete();
            m_rbeat = 0;
            return;
        end
        if (m_dir == 1) m_rbeat = 0;
        m_dir = 0;
        m_wbeats.push_back(d);
        if (m_wbeats.size() == NB) begin
            v = '0;
            foreach (m_wbeats[i]) v = v | (RW'(m_wbeats[i]) << (i * DW));
            wr_q.push_back('{addr: AW'(m_ar), data: v});
            m_inc();
            m_wbeats.delete();
        end
    endfunction

    function automatic void m_read(input bit sel);
        if (!sel) begin
            m_dout = DW'(m_ar);
            return;
        end
        if (m_dir == 0) m_wbeats.delete();
        m_dir = 1;
        if (m_rbeat == 0) m_snap = core_mem[m_ar];
        m_dout = DW'(m_snap >> (m_rbeat * DW));
        m_rbeat++;
        if (m_rbeat == NB) begin
            rdc_q.push_back(AW'(m_ar));
            m_inc();
            m_rbeat = 0;
        end
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_stb) begin
                if (wr_q.size() == 0) check("unexpected_wr_stb", 32'd1, 32'd0);
                else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(wr_addr), 32'(e.addr));
                    check("wr_data", 32'(wr_data), 32'(e.data));
                end
            end
            if (rdc_stb) begin
                if (rdc_q.size() == 0) check("unexpected_rdc_stb", 32'd1, 32'd0);
                else begin
                    logic [AW-1:0] a;
                    a = rdc_q.pop_front();
                    check("rdc_addr", 32'(rdc_addr), 32'(a));
                end
            end
        end
        if (chk_q.size() != 0) begin
            chk_t c;
            c = chk_q.pop_front();
            check("dout", 32'(dout), 32'(c.dout));
            check("rd_addr", 32'(rd_addr), 32'(c.ar));
            if (c.rst) begin
                check("rst_wr_stb", 32'(wr_stb), 32'd0);
                check("rst_rdc_stb", 32'(rdc_stb), 32'd0);
                check("rst_wr_addr", 32'(wr_addr), 32'd0);
                check("rst_wr_data", 32'(wr_data), 32'd0);
                check("rst_rdc_addr", 32'(rdc_addr), 32'd0);
            end
        end
        if (final_chk) begin
            final_chk <= 0;
            check("wr_stb_missing", 32'(wr_q.size()), 32'd0);
            check("rdc_stb_missing", 32'(rdc_q.size()), 32'd0);
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        wr_q.delete();
        rdc_q.delete();
        m_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk_q.push_back('{ar: '0, dout: '0, rst: 1'b1});
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic access(input bit w, input bit r, input bit sel, input logic [DW-1:0] d);
        if (w) m_write(sel, d);
        else if (r) m_read(sel);
        rs = sel;
        din = d;
        if (w) nwr = 1'b0;
        if (r) nrd = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk_q.push_back('{ar: AW'(m_ar), dout: m_dout, rst: 1'b0});
        repeat (2) @(posedge clk);
        #1;
        nwr = 1'b1;
        nrd = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic wr(input bit sel, input logic [DW-1:0] d); access(1, 0, sel, d); endtask
    task automatic rd(input bit sel); access(0, 1, sel, '0); endtask

    initial begin
        int op;
        for (int i = 0; i < DEPTH; i++) core_mem[i] = RW'($urandom);
        do_reset();
        rd(0);
        // Set AR=3, write 0x5A, read back AR=4
        wr(0, 4'h3); wr(1, 4'hA); wr(1, 4'h5); rd(0);
        // AR=0: no auto-increment
        wr(0, 4'h0); wr(1, 4'h1); wr(1, 4'h2); wr(1, 4'h3); wr(1, 4'h4); rd(0);
        // Coherent read while the core changes mid-register
        core_mem[7] = 8'hC3;
        wr(0, 4'h7); rd(1);
        core_mem[7] = 8'hFF;
        rd(1); rd(0);
        // Wrap from 15 to 0, then stays at 0
        wr(0, 4'hF); wr(1, 4'h6); wr(1, 4'h9); rd(0); wr(1, 4'h7); wr(1, 4'h8); rd(0);
        // Direction change discards the partial write
        wr(0, 4'h5); wr(1, 4'hB); rd(1); rd(1); rd(0);
        // Simultaneous edges: write wins, DOUT unchanged
        wr(0, 4'h2); rd(0); access(1, 1, 1, 4'hD); access(1, 1, 1, 4'hE); rd(0);
        // Reset between beats
        wr(0, 4'h9); wr(1, 4'h1);
        do_reset();
        wr(1, 4'h2); rd(0);
        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            op = int'($urandom_range(0, 99));
            if (op < 8) wr(0, DW'($urandom));
            else if (op < 45) wr(1, DW'($urandom));
            else if (op < 55) rd(0);
            else if (op < 85) rd(1);
            else if (op < 90) access(1, 1, 1'($urandom), DW'($urandom));
            else if (op < 98) core_mem[$urandom_range(0, DEPTH - 1)] = RW'($urandom);
            else do_reset();
        end
        repeat (4) @(posedge clk);
        #1 final_chk = 1;
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
